dma_axi_write_engine: RTL and testbench

Parametrised AXI write master for the DMA peripheral. It takes one transfer command (start address, byte count, INCR/FIXED mode) and splits it into AXI bursts that never cross a 4KB boundary. It streams write data from the DMA data buffer and keeps up to MAX_OUTSTANDING bursts in flight. It checks every B response, reports the first error, and signals completion only after all responses have returned.

---
 rtl/dma_axi_write_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_dma_axi_write_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_write_engine.sv
// AXI write master for the DMA: splits one command into bursts that never cross
// a 4KB page, streams buffer data on W and tracks B responses until drained.
module dma_axi_write_engine #(
   parameter int BW_ADDR         = 32,
   parameter int BW_AXI_DATA     = 32,
   parameter int BW_AXI_ID       = 4,
   parameter int AXI_ID          = 0,
   parameter int MAX_BURST_LEN   = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int BW_XFER_BYTES   = 20
) (
   input  logic                     clk,
   input  logic                     rstnn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [BW_ADDR-1:0]       cmd_addr,
   input  logic [BW_XFER_BYTES-1:0] cmd_bytes,
   input  logic                     cmd_fixed,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [1:0]               err_resp,
   input  logic                     sdata_valid,
   input  logic [BW_AXI_DATA-1:0]   sdata,
   output logic                     sdata_ready,
   output logic [BW_AXI_ID-1:0]     awid,
   output logic [BW_ADDR-1:0]       awaddr,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [BW_AXI_ID-1:0]     wid,
   output logic [BW_AXI_DATA-1:0]   wdata,
   output logic [BW_AXI_DATA/8-1:0] wstrb,
   output logic                     wlast,
   output logic                     wvalid,
   input  logic                     wready,
   input  logic [BW_AXI_ID-1:0]     bid,
   input  logic [1:0]               bresp,
   input  logic                     bvalid,
   output logic                     bready
);
   localparam int NB      = BW_AXI_DATA / 8;
   localparam int NB_LOG  = $clog2(NB);
   localparam int FIX_MAX = (MAX_BURST_LEN > 16) ? 16 : MAX_BURST_LEN;
   localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int BEAT_W  = BW_XFER_BYTES + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   function automatic logic [NB-1:0] tail_strb(input logic [NB_LOG-1:0] rem);
      logic [NB-1:0] strb;
      for (int i = 0; i < NB; i++) begin
         strb[i] = (rem == NB_LOG'(0)) || (i < int'(rem));
      end
      return strb;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   state_t              state_r;
   logic                cmd_ready_r, busy_r, done_r, fixed_r, awvalid_r, err_r;
   logic [1:0]          err_resp_r;
   logic [BW_ADDR-1:0]  addr_r, awaddr_r;
   logic [BEAT_W-1:0]   beats_left_r;
   logic [NB-1:0]       last_strb_r;
   logic [7:0]          awlen_r;
   logic [8:0]          aw_len_r, beat_cnt_r;
   logic [CNT_W-1:0]    outstanding_r, fifo_cnt_r;
   logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
   logic [8:0]          fifo_len_r [MAX_OUTSTANDING];
   logic                fifo_fin_r [MAX_OUTSTANDING];

   logic [31:0]         beats_s, bound_s, cap_s, cap2_s, len_w_s;
   logic [8:0]          len_s, head_len_s;
   logic                aw_hs_s, w_hs_s, b_hs_s, pop_s, active_s, wlast_s, head_fin_s;
   logic                aw_final_s, fifo_full_s, out_ok_s;
   logic [CNT_W-1:0]    out_nx_s;
   logic                unused_ok_s;

   // Burst length: capped by burst limit, remaining beats and, for INCR, the 4KB page end.
   assign beats_s  = 32'(beats_left_r);
   assign bound_s  = 32'((13'h1000 - {1'b0, addr_r[11:0]}) >> NB_LOG);
   assign cap_s    = fixed_r ? 32'(FIX_MAX) : 32'(MAX_BURST_LEN);
   assign cap2_s   = (beats_s < cap_s) ? beats_s : cap_s;
   assign len_w_s  = (!fixed_r && (bound_s < cap2_s)) ? bound_s : cap2_s;
   assign len_s    = len_w_s[8:0];

   assign active_s    = (fifo_cnt_r != CNT_W'(0));
   assign head_len_s  = fifo_len_r[rd_ptr_r];
   assign head_fin_s  = fifo_fin_r[rd_ptr_r];
   assign wlast_s     = active_s && (beat_cnt_r == head_len_s - 9'd1);
   assign aw_hs_s     = awvalid_r && awready;
   assign w_hs_s      = sdata_valid && active_s && wready;
   assign pop_s       = w_hs_s && wlast_s;
   assign b_hs_s      = bvalid && (outstanding_r != CNT_W'(0));
   assign aw_final_s  = (beats_left_r == BEAT_W'(aw_len_r));
   assign fifo_full_s = (fifo_cnt_r == CNT_W'(MAX_OUTSTANDING));
   assign out_ok_s    = (outstanding_r < CNT_W'(MAX_OUTSTANDING));
   assign out_nx_s    = (aw_hs_s && !b_hs_s) ? outstanding_r + CNT_W'(1) :
                        (!aw_hs_s && b_hs_s) ? outstanding_r - CNT_W'(1) : outstanding_r;

   assign cmd_ready   = cmd_ready_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign err         = err_r;
   assign err_resp    = err_resp_r;
   assign awid        = BW_AXI_ID'(AXI_ID);
   assign awaddr      = awaddr_r;
   assign awlen       = awlen_r;
   assign awsize      = 3'(NB_LOG);
   assign awburst     = fixed_r ? 2'b00 : 2'b01;
   assign awvalid     = awvalid_r;
   assign wid         = BW_AXI_ID'(AXI_ID);
   assign wdata       = sdata;
   assign wvalid      = sdata_valid && active_s;
   assign sdata_ready = wready && active_s;
   assign wlast       = wlast_s;
   assign wstrb       = (wlast_s && head_fin_s) ? last_strb_r : {NB{1'b1}};
   assign bready      = 1'b1;
   assign unused_ok_s = ^{bid, cmd_addr[NB_LOG-1:0], len_w_s[31:9]};

   // Control FSM: command acceptance, AW issue and transfer completion.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_r      <= IDLE;
         cmd_ready_r  <= 1'b1;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         fixed_r      <= 1'b0;
         addr_r       <= BW_ADDR'(0);
         beats_left_r <= BEAT_W'(0);
         last_strb_r  <= {NB{1'b1}};
         awvalid_r    <= 1'b0;
         awaddr_r     <= BW_ADDR'(0);
         awlen_r      <= 8'd0;
         aw_len_r     <= 9'd0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (cmd_valid) begin
                  addr_r       <= {cmd_addr[BW_ADDR-1:NB_LOG], {NB_LOG{1'b0}}};
                  fixed_r      <= cmd_fixed;
                  beats_left_r <= (BEAT_W'(cmd_bytes) + BEAT_W'(NB - 1)) >> NB_LOG;
                  last_strb_r  <= tail_strb(cmd_bytes[NB_LOG-1:0]);
                  cmd_ready_r  <= 1'b0;
                  busy_r       <= 1'b1;
                  state_r      <= (cmd_bytes == BW_XFER_BYTES'(0)) ? DONE : RUN;
               end
            end
            RUN: begin
               if (aw_hs_s) begin
                  awvalid_r    <= 1'b0;
                  beats_left_r <= beats_left_r - BEAT_W'(aw_len_r);
                  if (!fixed_r) begin
                     addr_r <= addr_r + (BW_ADDR'(aw_len_r) << NB_LOG);
                  end
               end else if (awvalid_r) begin
                  awvalid_r <= 1'b1;
               end else if (beats_left_r == BEAT_W'(0)) begin
                  state_r <= DRAIN;
               end else if (out_ok_s && !fifo_full_s) begin
                  awvalid_r <= 1'b1;
                  awaddr_r  <= addr_r;
                  awlen_r   <= 8'(len_s - 9'd1);
                  aw_len_r  <= len_s;
               end
            end
            DRAIN: begin
               // Uses the post-B count so done follows the last response by one cycle.
               if ((fifo_cnt_r == CNT_W'(0)) && (out_nx_s == CNT_W'(0))) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end
            end
            DONE: begin
               if (done_r) begin
                  done_r      <= 1'b0;
                  state_r     <= IDLE;
                  cmd_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end else begin
                  done_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               cmd_ready_r <= 1'b1;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
               awvalid_r   <= 1'b0;
            end
         endcase
      end
   end

   // Burst-info FIFO and W beat counter; entries enter on AW and leave on wlast.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         wr_ptr_r   <= PTR_W'(0);
         rd_ptr_r   <= PTR_W'(0);
         fifo_cnt_r <= CNT_W'(0);
         beat_cnt_r <= 9'd0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_len_r[i] <= 9'd0;
            fifo_fin_r[i] <= 1'b0;
         end
      end else begin
         if (aw_hs_s) begin
            fifo_len_r[wr_ptr_r] <= aw_len_r;
            fifo_fin_r[wr_ptr_r] <= aw_final_s;
            wr_ptr_r             <= ptr_inc(wr_ptr_r);
         end
         if (w_hs_s) begin
            if (wlast_s) begin
               beat_cnt_r <= 9'd0;
               rd_ptr_r   <= ptr_inc(rd_ptr_r);
            end else begin
               beat_cnt_r <= beat_cnt_r + 9'd1;
            end
         end
         if (aw_hs_s && !pop_s) begin
            fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
         end else if (!aw_hs_s && pop_s) begin
            fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
         end
      end
   end

   // Outstanding-burst counter and first-error capture.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         outstanding_r <= CNT_W'(0);
         err_r         <= 1'b0;
         err_resp_r    <= 2'b00;
      end else begin
         outstanding_r <= out_nx_s;
         if (state_r == IDLE && cmd_valid) begin
            err_r      <= 1'b0;
            err_resp_r <= 2'b00;
         end else if (b_hs_s && (bresp != 2'b00) && !err_r) begin
            err_r      <= 1'b1;
            err_resp_r <= bresp;
         end
      end
   end
endmodule

// File: tb/tb_dma_axi_write_engine.sv
// Scoreboard bench for dma_axi_write_engine: expected AW/W traffic is queued per
// command and checked by a monitor on every handshake.
module tb_dma_axi_write_engine;
   logic        clk = 1'b0;
   logic        rstnn = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_fixed = 1'b0;
   logic [31:0] cmd_addr = 32'd0;
   logic [19:0] cmd_bytes = 20'd0;
   logic        busy, done, err;
   logic [1:0]  err_resp;
   logic        sdata_valid, sdata_ready;
   logic [31:0] sdata;
   logic [3:0]  awid, wid, bid;
   logic [31:0] awaddr, wdata;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst, bresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   dma_axi_write_engine #(.BW_ADDR(32), .BW_AXI_DATA(32), .BW_AXI_ID(4), .AXI_ID(0),
      .MAX_BURST_LEN(16), .MAX_OUTSTANDING(2), .BW_XFER_BYTES(20)) dut (
      .clk(clk), .rstnn(rstnn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes), .cmd_fixed(cmd_fixed),
      .busy(busy), .done(done), .err(err), .err_resp(err_resp),
      .sdata_valid(sdata_valid), .sdata(sdata), .sdata_ready(sdata_ready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready));

   typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] burst; } aw_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

   aw_t         exp_aw[$];
   w_t          exp_w[$];
   logic [1:0]  bq[$];
   logic [1:0]  bresp_tab [8];
   int          n_vec = 0, n_err = 0;
   int          cyc = 0;
   int          src_total = 0, src_idx = 0, burst_no = 0, aw_count = 0;
   int          done_cnt = 0, done_cyc = 0, accept_cyc = 0, last_b_cyc = 0;
   logic [31:0] src_base = 32'd0;
   logic        b_hold = 1'b0, stray_b = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input string what);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   task automatic push_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
      aw_t e;
      e.addr = a; e.len = l; e.burst = b;
      exp_aw.push_back(e);
   endtask

   task automatic push_w(input logic [31:0] d, input logic [3:0] s, input logic l);
      w_t e;
      e.data = d; e.strb = s; e.last = l;
      exp_w.push_back(e);
   endtask

   // Monitor: pops and compares on every AW/W handshake, tracks B and done.
   initial begin
      aw_t ea;
      w_t  ew;
      forever begin
         @(negedge clk);
         if (rstnn) begin
            if (awvalid && awready) begin
               aw_count++;
               if (exp_aw.size() == 0) flag("aw_unexpected", "AW handshake with nothing expected");
               else begin
                  ea = exp_aw.pop_front();
                  check("awaddr", awaddr, ea.addr);
                  check("awlen", 32'(awlen), 32'(ea.len));
                  check("awburst", 32'(awburst), 32'(ea.burst));
                  check("awsize", 32'(awsize), 32'd2);
                  check("awid", 32'(awid), 32'd0);
               end
            end
            if (wvalid && wready) begin
               if (exp_w.size() == 0) flag("w_unexpected", "W handshake with nothing expected");
               else begin
                  ew = exp_w.pop_front();
                  check("wdata", wdata, ew.data);
                  check("wstrb", 32'(wstrb), 32'(ew.strb));
                  check("wlast", 32'(wlast), 32'(ew.last));
                  check("wid", 32'(wid), 32'd0);
               end
            end
            if (bvalid && bready) last_b_cyc = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
         end
      end
   end

   // Slave / data-source model: stall patterns, B responses one per completed burst.
   initial begin
      logic sd_hs, wl_hs, b_hs;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
      sdata_valid = 1'b0; sdata = 32'd0;
      forever begin
         @(negedge clk);
         sd_hs = sdata_valid && sdata_ready;
         wl_hs = wvalid && wready && wlast;
         b_hs  = bvalid && bready;
         @(posedge clk);
         #1;
         if (sd_hs) src_idx++;
         if (wl_hs) begin bq.push_back(bresp_tab[burst_no % 8]); burst_no++; end
         if (b_hs && bq.size() > 0) void'(bq.pop_front());
         awready     = (cyc % 3) != 1;
         wready      = (cyc % 4) != 2;
         sdata_valid = (src_idx < src_total) && ((cyc % 5) != 3);
         sdata       = src_base + 32'(src_idx);
         if (stray_b) begin
            bvalid = 1'b1; bresp = 2'b11;
         end else begin
            bvalid = (bq.size() > 0) && !b_hold;
            bresp  = (bq.size() > 0) ? bq[0] : 2'b00;
         end
      end
   end

   task automatic start(input logic [31:0] a, input int bytes, input logic fx, input logic [31:0] base);
      bit ok = 0;
      @(posedge clk);
      #2;
      src_base = base; src_idx = 0; src_total = (bytes + 3) / 4;
      burst_no = 0; aw_count = 0; done_cnt = 0;
      cmd_addr = a; cmd_bytes = 20'(bytes); cmd_fixed = fx; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; accept_cyc = cyc; end
      end
      if (!ok) flag("cmd_accept", "cmd_ready never seen within 20 cycles");
      @(posedge clk);
      #2;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int exp_aws);
      bit seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done_cnt > 0) seen = 1;
      end
      if (!seen) flag("done_timeout", "done not seen within 3000 cycles");
      repeat (4) @(negedge clk);
      check("done_count", 32'(done_cnt), 32'd1);
      check("aw_count", 32'(aw_count), 32'(exp_aws));
      check("aw_left", 32'(exp_aw.size()), 32'd0);
      check("w_left", 32'(exp_w.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) bresp_tab[i] = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'({err, err_resp}), 32'd0);
      check("rst_awvalid", 32'(awvalid), 32'd0);
      check("rst_wvalid", 32'({wvalid, wlast, sdata_ready}), 32'd0);
      check("rst_bready", 32'(bready), 32'd1);
      check("rst_awsize", 32'(awsize), 32'd2);
      rstnn = 1'b1;

      // 256 bytes INCR: four 16-beat bursts.
      for (int b = 0; b < 4; b++) push_aw(32'h1000 + 32'(b * 64), 8'd15, 2'b01);
      for (int i = 0; i < 64; i++) push_w(32'h100 + 32'(i), 4'hF, (i % 16) == 15);
      start(32'h1000, 256, 1'b0, 32'h100);
      wait_done(4);
      check("done_after_b", 32'(done_cyc - last_b_cyc), 32'd1);
      check("t1_err", 32'(err), 32'd0);

      // 4KB boundary split.
      push_aw(32'h1FF0, 8'd3, 2'b01);
      push_aw(32'h2000, 8'd11, 2'b01);
      for (int i = 0; i < 16; i++) push_w(32'h200 + 32'(i), 4'hF, (i == 3) || (i == 15));
      start(32'h1FF0, 64, 1'b0, 32'h200);
      wait_done(2);

      // Partial tail: 10 bytes.
      push_aw(32'h200, 8'd2, 2'b01);
      push_w(32'h300, 4'hF, 1'b0);
      push_w(32'h301, 4'hF, 1'b0);
      push_w(32'h302, 4'h3, 1'b1);
      start(32'h200, 10, 1'b0, 32'h300);
      wait_done(1);

      // Outstanding limit of 2 with B held off.
      b_hold = 1'b1;
      for (int b = 0; b < 4; b++) push_aw(32'h4000 + 32'(b * 64), 8'd15, 2'b01);
      for (int i = 0; i < 64; i++) push_w(32'h400 + 32'(i), 4'hF, (i % 16) == 15);
      start(32'h4000, 256, 1'b0, 32'h400);
      repeat (150) @(negedge clk);
      check("hold_aw_count", 32'(aw_count), 32'd2);
      check("hold_awvalid", 32'(awvalid), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      b_hold = 1'b0;
      wait_done(4);

      // Error responses on bursts 2 and 4: first one is kept.
      bresp_tab[1] = 2'b10;
      bresp_tab[3] = 2'b11;
      for (int b = 0; b < 4; b++) push_aw(32'h5000 + 32'(b * 64), 8'd15, 2'b01);
      for (int i = 0; i < 64; i++) push_w(32'h500 + 32'(i), 4'hF, (i % 16) == 15);
      start(32'h5000, 256, 1'b0, 32'h500);
      wait_done(4);
      check("err_flag", 32'(err), 32'd1);
      check("err_resp", 32'(err_resp), 32'd2);
      check("err_done_after_b", 32'(done_cyc - last_b_cyc), 32'd1);
      bresp_tab[1] = 2'b00;
      bresp_tab[3] = 2'b00;

      // Zero bytes: no traffic, accept clears err, done two cycles later.
      start(32'h3000, 0, 1'b0, 32'h0);
      check("err_cleared", 32'(err), 32'd0);
      wait_done(0);
      check("zero_done_lat", 32'(done_cyc - accept_cyc), 32'd2);

      // FIXED, 38 bytes at 0x1FF8: one 10-beat burst, no page split, tail strobe 0x3.
      push_aw(32'h1FF8, 8'd9, 2'b00);
      for (int i = 0; i < 10; i++) push_w(32'h600 + 32'(i), (i == 9) ? 4'h3 : 4'hF, i == 9);
      start(32'h1FF8, 38, 1'b1, 32'h600);
      wait_done(1);

      // Stray error B while nothing is outstanding must be ignored.
      @(posedge clk); #2; stray_b = 1'b1;
      @(posedge clk); #2; stray_b = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_b_err", 32'(err), 32'd0);

      // Reset in the middle of RUN.
      for (int b = 0; b < 4; b++) push_aw(32'h6000 + 32'(b * 64), 8'd15, 2'b01);
      for (int i = 0; i < 64; i++) push_w(32'h700 + 32'(i), 4'hF, (i % 16) == 15);
      start(32'h6000, 256, 1'b0, 32'h700);
      repeat (20) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rstnn = 1'b0;
      src_total = 0;
      #1;
      check("mid_rst_outs", 32'({awvalid, wvalid, wlast, sdata_ready, busy, done}), 32'd0);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);
      repeat (3) @(posedge clk);
      #3;
      exp_aw.delete(); exp_w.delete(); bq.delete(); src_idx = 0;
      @(negedge clk);
      rstnn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);

      // Recovery transfer after reset.
      push_aw(32'h200, 8'd2, 2'b01);
      push_w(32'h800, 4'hF, 1'b0);
      push_w(32'h801, 4'hF, 1'b0);
      push_w(32'h802, 4'h3, 1'b1);
      start(32'h200, 10, 1'b0, 32'h800);
      wait_done(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
